// File: rtl/malu_iter_pkg.sv
// Shared definitions for the iterative multiply/divide unit and the EXC stage that drives it.
// The divider datapath is compiled in only when MALU_DIV_EN is defined.
package malu_iter_pkg;

    localparam int unsigned XLEN = 64;
    localparam int unsigned CntW = $clog2(XLEN);

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StDone
    } malu_state_t;

    typedef logic [XLEN-1:0]   malu_word_t;
    typedef logic [2*XLEN-1:0] malu_result_t;

    // An operand counts as negative only when it is declared signed.
    function automatic logic malu_is_neg(input malu_word_t x, input logic is_signed);
        return is_signed & x[XLEN-1];
    endfunction

endpackage

// File: rtl/malu_iter_if.sv
// Start/ready handshake between the EXC pipeline stage (master) and malu_iter (slave).
interface malu_iter_if;
    import malu_iter_pkg::*;

    logic         start;
    logic         div_sel;
    malu_word_t   a;
    malu_word_t   b;
    logic         signed_a;
    logic         signed_b;
    malu_result_t result;
    logic         ready;

    modport master (
        output start, div_sel, a, b, signed_a, signed_b,
        input  result, ready
    );

    modport slave (
        input  start, div_sel, a, b, signed_a, signed_b,
        output result, ready
    );

endinterface

// File: rtl/malu_iter_signfix.sv
// Combinational sign handling: either one full-width conditional negate, or two independent
// half-width conditional negates (used for {|a|,|b|} on entry and {rem,quo} on exit).
module malu_iter_signfix
    import malu_iter_pkg::*;
(
    input  malu_result_t val_i,
    input  logic         wide_i,
    input  logic         neg_hi_i,
    input  logic         neg_lo_i,
    output malu_result_t val_o
);

    malu_word_t hi;
    malu_word_t lo;

    always_comb begin
        hi = val_i[2*XLEN-1:XLEN];
        lo = val_i[XLEN-1:0];
        if (wide_i) begin
            val_o = neg_lo_i ? -val_i : val_i;
        end else begin
            val_o = {(neg_hi_i ? -hi : hi), (neg_lo_i ? -lo : lo)};
        end
    end

endmodule

// File: rtl/malu_iter.sv
// Iterative radix-2 64-bit multiply/divide responder for the EXC stage.
// Restoring divider present only when MALU_DIV_EN is defined; otherwise divides return 0.
module malu_iter
    import malu_iter_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    malu_iter_if.slave  mif
);

    malu_state_t     state_q, state_d;
    logic [CntW-1:0] count_q, count_d;
    malu_result_t    acc_q, acc_d;
    malu_word_t      dvsr_q, dvsr_d;
    logic            neg_a_q, neg_a_d;
    logic            neg_b_q, neg_b_d;
    malu_result_t    result_q, result_d;
    logic            ready_q, ready_d;

    malu_result_t    op_abs;
    malu_result_t    step_acc;
    malu_result_t    fixed_res;
    logic            exit_wide;

    malu_iter_signfix u_entry_fix (
        .val_i    ({mif.a, mif.b}),
        .wide_i   (1'b0),
        .neg_hi_i (malu_is_neg(mif.a, mif.signed_a)),
        .neg_lo_i (malu_is_neg(mif.b, mif.signed_b)),
        .val_o    (op_abs)
    );

`ifdef MALU_DIV_EN
    logic            div_q, div_d;
    logic [XLEN+1:0] add_x, add_y, add_sum;

    // One adder: multiplicand add for MUL, 65-bit trial subtract (x + ~y + 1) for DIV.
    always_comb begin
        add_x   = div_q ? {1'b0, acc_q[2*XLEN-1:XLEN-1]} : {2'b00, acc_q[2*XLEN-1:XLEN]};
        add_y   = div_q ? ~{2'b00, dvsr_q} : {2'b00, dvsr_q};
        add_sum = add_x + add_y + {{(XLEN+1){1'b0}}, div_q};
        if (div_q) begin
            step_acc = add_sum[XLEN+1] ? {acc_q[2*XLEN-2:0], 1'b0}
                                       : {add_sum[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        end else begin
            step_acc = acc_q[0] ? {add_sum[XLEN:0], acc_q[XLEN-1:1]}
                                : {1'b0, acc_q[2*XLEN-1:1]};
        end
    end

    assign exit_wide = ~div_q;
`else
    logic [XLEN:0] add_sum;

    assign add_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, dvsr_q};
    assign step_acc  = acc_q[0] ? {add_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};
    assign exit_wide = 1'b1;
`endif

    // Product negates as a whole; quotient follows sign XOR, remainder follows the dividend.
    malu_iter_signfix u_exit_fix (
        .val_i    (step_acc),
        .wide_i   (exit_wide),
        .neg_hi_i (neg_a_q),
        .neg_lo_i (neg_a_q ^ neg_b_q),
        .val_o    (fixed_res)
    );

    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        acc_d    = acc_q;
        dvsr_d   = dvsr_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        ready_d  = 1'b0;
`ifdef MALU_DIV_EN
        div_d    = div_q;
`endif
        unique case (state_q)
            StIdle: begin
                if (mif.start) begin
                    neg_a_d = malu_is_neg(mif.a, mif.signed_a);
                    neg_b_d = malu_is_neg(mif.b, mif.signed_b);
                    count_d = '0;
                    if (mif.div_sel) begin
`ifdef MALU_DIV_EN
                        div_d  = 1'b1;
                        acc_d  = {{XLEN{1'b0}}, op_abs[2*XLEN-1:XLEN]};
                        dvsr_d = op_abs[XLEN-1:0];
                        if (mif.b == '0) begin
                            result_d = {mif.a, {XLEN{1'b1}}};
                            state_d  = StDone;
                            ready_d  = 1'b1;
                        end else begin
                            state_d  = StBusy;
                        end
`else
                        result_d = '0;
                        state_d  = StDone;
                        ready_d  = 1'b1;
`endif
                    end else begin
`ifdef MALU_DIV_EN
                        div_d   = 1'b0;
`endif
                        acc_d   = {{XLEN{1'b0}}, op_abs[XLEN-1:0]};
                        dvsr_d  = op_abs[2*XLEN-1:XLEN];
                        state_d = StBusy;
                    end
                end
            end
            StBusy: begin
                if (!mif.start) begin
                    // Pipeline flush: abandon silently, result keeps its old value.
                    state_d = StIdle;
                end else begin
                    acc_d   = step_acc;
                    count_d = count_q + 1'b1;
                    if (count_q == CntW'(XLEN - 1)) begin
                        result_d = fixed_res;
                        state_d  = StDone;
                        ready_d  = 1'b1;
                    end
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            count_q  <= '0;
            acc_q    <= '0;
            dvsr_q   <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            ready_q  <= 1'b0;
`ifdef MALU_DIV_EN
            div_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            acc_q    <= acc_d;
            dvsr_q   <= dvsr_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            ready_q  <= ready_d;
`ifdef MALU_DIV_EN
            div_q    <= div_d;
`endif
        end
    end

    assign mif.result = result_q;
    assign mif.ready  = ready_q;

endmodule

// File: tb/tb_malu_iter.sv
// Randomized self-checking bench for malu_iter against an arithmetic reference model.
module tb_malu_iter;
    import malu_iter_pkg::*;

    logic clk;
    logic rst_n;
    int   vec_cnt;
    int   err_cnt;

    malu_iter_if mif ();

    malu_iter dut (
        .clk   (clk),
        .rst_n (rst_n),
        .mif   (mif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] model(input logic [63:0] a, input logic [63:0] b,
                                           input logic sa, input logic sb, input logic ds);
        logic signed [129:0] ea, eb, p, q, r;
        ea = sa ? {{66{a[63]}}, a} : {66'b0, a};
        eb = sb ? {{66{b[63]}}, b} : {66'b0, b};
        if (!ds) begin
            p = ea * eb;
            return p[127:0];
        end
`ifdef MALU_DIV_EN
        if (b == 64'd0) return {a, {64{1'b1}}};
        q = ea / eb;
        r = ea % eb;
        return {r[63:0], q[63:0]};
`else
        return 128'd0;
`endif
    endfunction

    function automatic int model_lat(input logic [63:0] b, input logic ds);
`ifdef MALU_DIV_EN
        return (ds && b == 64'd0) ? 1 : 65;
`else
        return ds ? 1 : 65;
`endif
    endfunction

    task automatic drive(input logic [63:0] a, input logic [63:0] b,
                         input logic sa, input logic sb, input logic ds);
        mif.a        = a;
        mif.b        = b;
        mif.signed_a = sa;
        mif.signed_b = sb;
        mif.div_sel  = ds;
        mif.start    = 1'b1;
    endtask

    // Counts edges until ready; scrambles operands while busy to show they are ignored.
    task automatic wait_ready(output int lat);
        bit got;
        got = 1'b0;
        lat = 0;
        while (!got && lat < 200) begin
            @(posedge clk);
            #1;
            lat++;
            if (mif.ready) got = 1'b1;
            else begin
                mif.a        = {$urandom, $urandom};
                mif.b        = {$urandom, $urandom};
                mif.signed_a = 1'($urandom);
                mif.signed_b = 1'($urandom);
                mif.div_sel  = 1'($urandom);
            end
        end
    endtask

    task automatic finish_op();
        @(negedge clk);
        mif.start = 1'b0;
        @(posedge clk);
        #1;
        check_eq("ready_pulse", 128'(mif.ready), 128'd0);
    endtask

    task automatic run_op(input string tag, input logic [63:0] a, input logic [63:0] b,
                          input logic sa, input logic sb, input logic ds);
        int lat;
        @(negedge clk);
        drive(a, b, sa, sb, ds);
        wait_ready(lat);
        check_eq({tag, "_lat"}, 128'(lat), 128'(model_lat(b, ds)));
        check_eq({tag, "_res"}, mif.result, model(a, b, sa, sb, ds));
        finish_op();
    endtask

    logic [63:0]  ra, rb;
    logic [127:0] held;
    int           lat, nready;

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n = 1'b0;
        mif.start = 1'b0;
        mif.a = '0;
        mif.b = '0;
        mif.signed_a = 1'b0;
        mif.signed_b = 1'b0;
        mif.div_sel = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_ready", 128'(mif.ready), 128'd0);
        check_eq("rst_result", mif.result, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        run_op("umul", 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 1'b0, 1'b0, 1'b0);
        check_eq("umul_lit", mif.result, 128'h1_FFFF_FFFF_FFFF_FFFE);
        run_op("smul", -64'sd3, 64'd7, 1'b1, 1'b1, 1'b0);
        run_op("sumul", -64'sd1, 64'd2, 1'b1, 1'b0, 1'b0);
        run_op("sdiv", -64'sd7, 64'd2, 1'b1, 1'b1, 1'b1);
        run_op("ovfdiv", 64'h8000_0000_0000_0000, -64'sd1, 1'b1, 1'b1, 1'b1);
        run_op("div0", 64'd5, 64'd0, 1'b0, 1'b0, 1'b1);

        // Abort in BUSY cycle 10: no ready, result untouched.
        held = mif.result;
        @(negedge clk);
        drive(64'd123, 64'd456, 1'b0, 1'b0, 1'b0);
        repeat (10) @(posedge clk);
        #1;
        mif.start = 1'b0;
        nready = 0;
        for (int i = 0; i < 70; i++) begin
            @(posedge clk);
            #1;
            if (mif.ready) nready++;
        end
        check_eq("abort_noready", 128'(nready), 128'd0);
        check_eq("abort_result", mif.result, held);
        run_op("after_abort", 64'hDEAD_BEEF_0000_1234, 64'h0000_0001_0000_0003, 1'b0, 1'b0, 1'b0);

        // Asynchronous reset in BUSY cycle 30 clears the visible outputs at once.
        @(negedge clk);
        drive(64'd99, 64'd77, 1'b0, 1'b0, 1'b0);
        repeat (30) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_ready", 128'(mif.ready), 128'd0);
        check_eq("midrst_result", mif.result, 128'd0);
        mif.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Back-to-back: start stays high through ready while new operands are presented.
        @(negedge clk);
        drive(-64'sd11, 64'd13, 1'b1, 1'b1, 1'b0);
        wait_ready(lat);
        check_eq("b2b1_lat", 128'(lat), 128'd65);
        check_eq("b2b1_res", mif.result, model(-64'sd11, 64'd13, 1'b1, 1'b1, 1'b0));
        drive(64'd1000, 64'd7, 1'b0, 1'b0, 1'b1);
        wait_ready(lat);
        check_eq("b2b2_lat", 128'(lat), 128'(model_lat(64'd7, 1'b1) + 1));
        check_eq("b2b2_res", mif.result, model(64'd1000, 64'd7, 1'b0, 1'b0, 1'b1));
        finish_op();

        for (int i = 0; i < 40; i++) begin
            ra = {$urandom, $urandom};
            rb = {$urandom, $urandom};
            case ($urandom_range(0, 7))
                0: rb = 64'd0;
                1: ra = 64'h8000_0000_0000_0000;
                2: rb = {64{1'b1}};
                3: rb = 64'($urandom_range(1, 9));
                default: ;
            endcase
            run_op("rand", ra, rb, 1'($urandom), 1'($urandom), 1'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/malu_iter.md
# malu_iter

Iterative 64-bit integer multiply/divide unit that responds to the start/ready handshake driven by the EXC pipeline stage. It captures operands on an accepted start, runs one radix-2 iteration per cycle, and returns a 128-bit result with a one-cycle ready pulse. While it runs, the EXC stage holds start high and the pipeline stalls. It is the responder end of the EXC-stage multiply interface.

## Interface
- XLEN, 64, operand width; result is 2*XLEN, iteration count is XLEN
- clk  input  1  clock, all state updates on rising edge
- reset  input  1  asynchronous, active-low reset
- start  input  1  level request; held high by initiator until it sees ready
- div_sel  input  1  0 = multiply, 1 = divide; sampled with operands
- a  input  XLEN  multiplicand / dividend
- b  input  XLEN  multiplier / divisor
- signed_a  input  1  treat a as two's complement
- signed_b  input  1  treat b as two's complement
- result  output  2*XLEN  MUL: full product; DIV: {remainder, quotient}
- ready  output  1  one-cycle completion pulse; result valid from this cycle until the next acceptance

## Operation
- States: IDLE, BUSY, DONE.
- IDLE: when start=1, latch magnitudes |a| and |b|, the result sign flags, and div_sel, then go to BUSY with count=0. |x| = -x only when signed_x=1 and x[XLEN-1]=1. An operand of -2^63 has magnitude 2^63 and fits unsigned.
- MUL, shift-add over 128-bit accumulator: if multiplier LSB=1, add multiplicand to the upper half; then shift right 1. Final product is negated when sign_a XOR sign_b.
- DIV, restoring: shift {rem, quo} left 1, trial-subtract the divisor from rem, and keep it if no borrow, with quotient bit = NOT borrow. The quotient is negated when the signs differ. The remainder takes the dividend's sign.
- Divide by zero (b=0, checked at acceptance): skip BUSY and go directly to DONE with quotient = all-ones and remainder = a unmodified.
- Signed overflow (-2^63 / -1): falls out of the magnitude algorithm as quotient 0x8000_0000_0000_0000, remainder 0. No special case is needed.
- BUSY: one iteration per cycle. After iteration XLEN-1, apply the sign fix-up, write result, and go to DONE.
- BUSY with start=0: abort, return to IDLE, no ready, result unchanged. This is the pipeline flush path.
- DONE: ready=1 for exactly this cycle, then go to IDLE unconditionally. A start seen in the following IDLE cycle is a new operation, so back-to-back issue works.
- Reset (any state, mid-operation included): state=IDLE, count=0, result=0, ready=0. Internal accumulators are cleared.

## Timing
- Start is accepted at the edge ending cycle N (IDLE, start=1). BUSY occupies cycles N+1..N+64, and ready is high in cycle N+65: 65 cycles from start to ready.
- Divide by zero: ready in cycle N+1.
- ready is registered and never high in two consecutive cycles.
- result only changes on the DONE-entry edge or on reset.
- Operands are sampled only at acceptance. Changes to a, b, or the sign/div_sel inputs during BUSY are ignored.
- Minimum issue interval is 66 cycles (acceptance, 64 BUSY, DONE, then a new acceptance the cycle after DONE).

## Configuration
- MALU_DIV_EN defined: divider is compiled in as described.
- MALU_DIV_EN undefined: the divide datapath is removed. div_sel=1 is still accepted, goes directly to DONE (ready in cycle N+1), and result = 0.
- Multiply behaviour is identical either way.

## Structure
- Shared package holds the XLEN constant, the malu_state_t enum (IDLE/BUSY/DONE), and a 2*XLEN result typedef. The EXC stage imports the same package.
- A single 128-bit shift register plus a 65-bit adder/subtractor is shared by MUL and DIV.
- The natural sub-module is malu_signfix: combinational abs/negate for operand entry and result exit, instantiated twice.

## Test plan
- Unsigned MUL: a=0xFFFF_FFFF_FFFF_FFFF, b=2, signed=0/0, start held -> ready in cycle N+65, result=0x1_FFFF_FFFF_FFFF_FFFE.
- Signed MUL: a=-3, b=7, signed=1/1 -> result = -21 sign-extended to 128 bits. With signed_a=1, signed_b=0, a=-1, b=2 -> result = -2 (mulhsu path).
- Signed DIV: a=-7, b=2 -> quotient -3, remainder -1. Also a=0x8000_0000_0000_0000, b=-1 -> quotient 0x8000_0000_0000_0000, remainder 0.
- Divide by zero: a=5, b=0, div_sel=1 -> ready in cycle N+1, quotient all-ones, remainder 5.
- Abort: drop start in BUSY cycle 10 -> no ready, result unchanged. Reassert start with new operands -> fresh 65-cycle run with the correct result.
- Reset in BUSY cycle 30 -> ready=0, result=0 immediately. Back-to-back: start held through ready with new operands -> second ready exactly 66 cycles after the first.
